mux_rr_sel_ctrl: RTL and testbench
==================================

// Module: mux_rr_sel_ctrl
// PURPOSE
//   Round-robin select controller that sits directly upstream of the 8:1 mux (mux_if, width=4, swidth=3).
//   Arbitrates among 8 channel requests and drives the mux sel.
//   Captures the mux output o into a registered valid/ready output stage, tagged with the channel number.
//   Pulses a one-hot ack back to the channel whose data was taken.
// PARAMETERS
//   width  4  data width of each mux input and of o_data
//   swidth 3  select width; fixed at 3 (8 channels); other values unsupported
// PORTS
//   clk      in   1       rising-edge clock
//   rst      in   1       synchronous, active-high reset
//   req      in   8       req[k]=1: channel k (mux input ik) holds data to send
//   mux_o    in   width   combinational o of the downstream mux
//   sel      out  swidth  registered select to mux sel
//   ack      out  8       one-hot, 1-cycle pulse: channel k data captured
//   o_data   out  width   captured data
//   o_ch     out  swidth  channel index of o_data
//   o_valid  out  1       o_data/o_ch valid
//   o_ready  in   1       consumer accepts when o_valid&&o_ready
// BEHAVIOUR
//   Reset (rst=1 at clk edge): sel=0, ack=0, o_data=0, o_ch=0, o_valid=0, ptr=0, state=IDLE.
//   Reset mid-operation drops any pending capture; no ack is issued.
//   ptr (3b, internal) = first channel checked by the next arbitration.
//   FSM: IDLE -> CAPT -> HOLD -> IDLE.
//   IDLE: req sampled here only.
//     If req==0: stay in IDLE, sel holds.
//     Else: sel<=winner, the first set req[k] scanning k=ptr,ptr+1,...,7,0,... (mod 8); go to CAPT.
//   CAPT: mux_o is valid for sel.
//     o_data<=mux_o, o_ch<=sel, o_valid<=1, ack<=(8'b1<<sel), ptr<=sel+1 (7 wraps to 0); go to HOLD.
//     req changes during CAPT are ignored; the capture still occurs.
//   HOLD: ack<=0. o_data, o_ch and sel stay stable while o_valid&&!o_ready.
//     On o_valid&&o_ready: o_valid<=0, go to IDLE.
//   Latency: req seen in IDLE at edge t -> sel at t+1 -> o_valid/ack at t+2.
//     Earliest next sel update is the edge after the handshake.
//   Max throughput: 1 transfer per 3 cycles (o_ready tied 1).
//   ack is high for exactly one cycle per transfer and is never high outside the CAPT->HOLD edge.
//   Upstream channel must keep its mux input stable from req until its ack.
//   Channel deasserts req after ack; a req still high is treated as new data.
// CONFIGURATION
//   MUX_FIXED_PRIO_EN defined: fixed priority, lowest set req index wins; ptr is not updated (held at 0).
//   MUX_FIXED_PRIO_EN undefined (default): round-robin from ptr as above.
//   Ports, latency and handshake are identical in both builds.
// TESTING (bench instantiates mux_if width=4 swidth=3, with sel/o wired to this block)
//   1. rst=1 for 2 cycles -> sel=0, ack=0, o_valid=0, o_data=0, o_ch=0.
//   2. req=8'h04, i2=4'hC, o_ready=1 -> sel=2 at t+1; o_valid=1, o_data=4'hC, o_ch=2, ack=8'h04 for 1 cycle at t+2.
//   3. req=8'hFF held, o_ready=1, ik=4'hA+k -> o_ch sequence 0,1,...,7,0; o_data matches each channel.
//   4. Grant ch6, then req=8'h81 -> next grant ch7, then ch0 (ptr wrap).
//   5. o_ready=0 for 5 cycles after o_valid -> o_valid, o_data, o_ch and sel stable; no second ack.
//      Then o_ready=1 -> o_valid=0 next cycle.
//   6. rst=1 during HOLD -> o_valid=0, ptr=0 next cycle; then req=8'h30 -> grant ch4.
//   7. MUX_FIXED_PRIO_EN defined, req=8'hFF held -> every grant is ch0.

Source files
------------

// File: rtl/mux_rr_sel_ctrl.sv
// rtl/mux_rr_sel_ctrl.sv - round-robin select controller for an 8:1 mux with registered valid/ready capture stage
// Optional build macro MUX_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module mux_rr_sel_ctrl #(
  parameter int width  = 4,
  parameter int swidth = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        req,
  input  logic [width-1:0]  mux_o,
  output logic [swidth-1:0] sel,
  output logic [7:0]        ack,
  output logic [width-1:0]  o_data,
  output logic [swidth-1:0] o_ch,
  output logic              o_valid,
  input  logic              o_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q;
  logic [swidth-1:0] sel_q;
  logic [7:0]        ack_q;
  logic [width-1:0]  o_data_q;
  logic [swidth-1:0] o_ch_q;
  logic              o_valid_q;
  logic [swidth-1:0] ptr_q;

  logic [swidth-1:0] scan_base;
  logic [swidth-1:0] win_d;
  logic [swidth-1:0] ptr_d;

`ifdef MUX_FIXED_PRIO_EN
  assign scan_base = '0;
  assign ptr_d     = '0;
`else
  assign scan_base = ptr_q;
  assign ptr_d     = sel_q + swidth'(1);
`endif

  // First requesting channel found walking upward from scan_base, wrapping mod 8.
  function automatic logic [swidth-1:0] pick_winner(input logic [7:0] r,
                                                    input logic [swidth-1:0] base);
    logic [swidth-1:0] idx;
    logic              found;
    logic [swidth-1:0] win;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = base + swidth'(i);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    win_d = pick_winner(req, scan_base);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ack_q     <= '0;
      o_data_q  <= '0;
      o_ch_q    <= '0;
      o_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (|req) begin
            sel_q   <= win_d;
            state_q <= CAPT;
          end
        end
        CAPT: begin
          o_data_q  <= mux_o;
          o_ch_q    <= sel_q;
          o_valid_q <= 1'b1;
          ack_q     <= 8'(1) << sel_q;
          ptr_q     <= ptr_d;
          state_q   <= HOLD;
        end
        HOLD: begin
          ack_q <= '0;
          if (o_valid_q && o_ready) begin
            o_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          ack_q     <= '0;
          o_valid_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign sel     = sel_q;
  assign ack     = ack_q;
  assign o_data  = o_data_q;
  assign o_ch    = o_ch_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_mux_rr_sel_ctrl.sv
// tb/tb_mux_rr_sel_ctrl.sv - table-driven and directed-sequence bench for mux_rr_sel_ctrl
module tb_mux_rr_sel_ctrl;

`ifdef MUX_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [3:0] mux_o;
  logic [2:0] sel;
  logic [7:0] ack;
  logic [3:0] o_data;
  logic [2:0] o_ch;
  logic       o_valid;
  logic       o_ready;

  logic [3:0] ch_data [8];

  always #5 clk = ~clk;

  // Stand-in for the downstream 8:1 mux: channel k presents 4'hA + k.
  assign mux_o = ch_data[sel];

  mux_rr_sel_ctrl #(.width(4), .swidth(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mux_o   (mux_o),
    .sel     (sel),
    .ack     (ack),
    .o_data  (o_data),
    .o_ch    (o_ch),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic [2:0] sel;
    logic [7:0] ack;
    logic       v;
    logic [3:0] d;
    logic [2:0] ch;
  } vec_t;

  vec_t vecs[$];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_sel, input logic [7:0] e_ack,
                         input logic e_v, input logic [3:0] e_d, input logic [2:0] e_ch);
    chk({tag, ".sel"},     32'(sel),     32'(e_sel));
    chk({tag, ".ack"},     32'(ack),     32'(e_ack));
    chk({tag, ".o_valid"}, 32'(o_valid), 32'(e_v));
    chk({tag, ".o_data"},  32'(o_data),  32'(e_d));
    chk({tag, ".o_ch"},    32'(o_ch),    32'(e_ch));
  endtask

  task automatic add(input logic r, input logic [7:0] rq, input logic rd, input logic [2:0] s,
                     input logic [7:0] a, input logic v, input logic [3:0] d, input logic [2:0] c);
    vec_t t;
    t.rst = r; t.req = rq; t.rdy = rd; t.sel = s; t.ack = a; t.v = v; t.d = d; t.ch = c;
    vecs.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] e;
    for (int k = 0; k < 8; k++) ch_data[k] = 4'hA + 4'(k);
    rst = 1'b1; req = 8'h00; o_ready = 1'b1;

    // Each row: inputs held across one edge, outputs expected just after it.
    add(1, 8'h00, 1, 3'd0, 8'h00, 0, 4'h0, 3'd0);
    add(1, 8'h00, 1, 3'd0, 8'h00, 0, 4'h0, 3'd0);
    add(0, 8'h00, 1, 3'd0, 8'h00, 0, 4'h0, 3'd0);
    add(0, 8'h04, 1, 3'd2, 8'h00, 0, 4'h0, 3'd0);
    add(0, 8'h00, 1, 3'd2, 8'h04, 1, 4'hC, 3'd2);
    add(0, 8'h00, 1, 3'd2, 8'h00, 0, 4'hC, 3'd2);
    add(0, 8'h00, 1, 3'd2, 8'h00, 0, 4'hC, 3'd2);
    // ch6 grant, then req=81: round-robin gives ch7 then ch0; fixed priority gives ch0 twice
    add(0, 8'h40, 1, 3'd6, 8'h00, 0, 4'hC, 3'd2);
    add(0, 8'h81, 1, 3'd6, 8'h40, 1, 4'h0, 3'd6);
    add(0, 8'h81, 1, 3'd6, 8'h00, 0, 4'h0, 3'd6);
    add(0, 8'h81, 1, FIXED ? 3'd0 : 3'd7, 8'h00, 0, 4'h0, 3'd6);
    add(0, 8'h00, 1, FIXED ? 3'd0 : 3'd7, FIXED ? 8'h01 : 8'h80, 1,
        FIXED ? 4'hA : 4'h1, FIXED ? 3'd0 : 3'd7);
    add(0, 8'h00, 1, FIXED ? 3'd0 : 3'd7, 8'h00, 0, FIXED ? 4'hA : 4'h1, FIXED ? 3'd0 : 3'd7);
    add(0, 8'h81, 1, 3'd0, 8'h00, 0, FIXED ? 4'hA : 4'h1, FIXED ? 3'd0 : 3'd7);
    add(0, 8'h00, 1, 3'd0, 8'h01, 1, 4'hA, 3'd0);
    add(0, 8'h00, 1, 3'd0, 8'h00, 0, 4'hA, 3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; req = vecs[i].req; o_ready = vecs[i].rdy;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].ack, vecs[i].v, vecs[i].d, vecs[i].ch);
    end

    // req=FF held: round-robin walks 0..7,0; fixed priority always ch0
    rst = 1'b1; req = 8'h00; step();
    rst = 1'b0;
    for (int n = 0; n < 9; n++) begin
      e = FIXED ? 3'd0 : 3'(n % 8);
      req = 8'hFF; o_ready = 1'b1;
      step();
      chk($sformatf("ff%0d.sel", n), 32'(sel), 32'(e));
      chk($sformatf("ff%0d.ack_early", n), 32'(ack), 32'h0);
      step();
      chk_all($sformatf("ff%0d.capt", n), e, 8'(1) << e, 1'b1, 4'hA + 4'(e), e);
      step();
      chk($sformatf("ff%0d.valid_drop", n), 32'(o_valid), 32'h0);
      chk($sformatf("ff%0d.ack_drop", n), 32'(ack), 32'h0);
    end
    req = 8'h00; step();

    // Backpressure: outputs frozen, no second ack while o_ready=0
    req = 8'h08; o_ready = 1'b0;
    step();
    chk("bp.sel", 32'(sel), 32'd3);
    step();
    chk_all("bp.capt", 3'd3, 8'h08, 1'b1, 4'hD, 3'd3);
    for (int c = 0; c < 5; c++) begin
      step();
      chk_all($sformatf("bp.hold%0d", c), 3'd3, 8'h00, 1'b1, 4'hD, 3'd3);
    end
    req = 8'h00; o_ready = 1'b1;
    step();
    chk_all("bp.release", 3'd3, 8'h00, 1'b0, 4'hD, 3'd3);
    step();
    chk_all("bp.idle", 3'd3, 8'h00, 1'b0, 4'hD, 3'd3);

    // Reset while in CAPT: capture dropped, no ack
    req = 8'h01; step();
    chk("rc.sel", 32'(sel), 32'd0);
    rst = 1'b1; req = 8'h00; step();
    chk_all("rc.rst", 3'd0, 8'h00, 1'b0, 4'h0, 3'd0);
    rst = 1'b0; step();
    chk_all("rc.after", 3'd0, 8'h00, 1'b0, 4'h0, 3'd0);

    // Reset in HOLD after ch4 grant; ptr must return to 0 so req=30 grants ch4, not ch5
    req = 8'h10; o_ready = 1'b0; step();
    chk("rh.sel", 32'(sel), 32'd4);
    step();
    chk_all("rh.capt", 3'd4, 8'h10, 1'b1, 4'hE, 3'd4);
    rst = 1'b1; req = 8'h00; step();
    chk_all("rh.rst", 3'd0, 8'h00, 1'b0, 4'h0, 3'd0);
    rst = 1'b0; req = 8'h30; o_ready = 1'b1; step();
    chk("rh.sel2", 32'(sel), 32'd4);
    req = 8'h00; step();
    chk_all("rh.capt2", 3'd4, 8'h10, 1'b1, 4'hE, 3'd4);
    step();
    chk_all("rh.done", 3'd4, 8'h00, 1'b0, 4'hE, 3'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
